// File: rtl/sdram_burst_arbiter_if.sv
// rtl/sdram_burst_arbiter_if.sv - client-level / controller-command bundle for the SDRAM burst arbiter
interface sdram_burst_arbiter_if;
   logic [9:0]  wr0_level;
   logic [9:0]  wr1_level;
   logic [9:0]  rd_level;
   logic        rd_sel;
   logic        ready;
   logic        f2s_data_valid;
   logic        rw;
   logic        rw_en;
   logic [11:0] f_addr;
   logic        wsel;
   logic        wr0_pop;
   logic        wr1_pop;
   logic        frame0_done;
   logic        err;

   modport master (
      input  wr0_level, wr1_level, rd_level, rd_sel, ready, f2s_data_valid,
      output rw, rw_en, f_addr, wsel, wr0_pop, wr1_pop, frame0_done, err
   );

   modport slave (
      output wr0_level, wr1_level, rd_level, rd_sel, ready, f2s_data_valid,
      input  rw, rw_en, f_addr, wsel, wr0_pop, wr1_pop, frame0_done, err
   );
endinterface

// File: rtl/sdram_burst_arbiter.sv
// rtl/sdram_burst_arbiter.sv - full-page burst scheduler for two write sources and one read sink
module sdram_burst_arbiter #(
   parameter int unsigned BURST_LEN   = 512,
   parameter int unsigned WR_THRESH   = 512,
   parameter int unsigned RD_THRESH   = 250,
   parameter int unsigned RD_URGENT   = 64,
   parameter int unsigned PAGES       = 600,
   parameter int unsigned BASE0       = 0,
   parameter int unsigned BASE1       = 600,
   parameter int unsigned ACK_TIMEOUT = 8,
   parameter int unsigned STARVE_MAX  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sdram_burst_arbiter_if.master arb_io
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK, S_BURST} state_e;
   typedef enum logic [1:0] {G_NONE, G_WR0, G_WR1, G_RD} grant_e;

   state_e      state_q, state_d;
   grant_e      winner;
   logic [9:0]  p0_q, p0_d, p1_q, p1_d, pr_q, pr_d;
   logic [2:0]  starve_q, starve_d;
   logic [9:0]  pop_cnt_q, pop_cnt_d;
   logic [3:0]  ack_cnt_q, ack_cnt_d;
   logic        region_q, region_d, region_sel;
   logic        err_q, err_d;
   logic        rw_q, rw_d;
   logic        wsel_q, wsel_d;
   logic [11:0] f_addr_q, f_addr_d;
   logic        frame0_q, frame0_d;
   logic        wr0_el, wr1_el, rd_el, rd_urg;
   logic        pop_ok;

   function automatic logic [9:0] ptr_inc(input logic [9:0] p);
      return (p == 10'(PAGES - 1)) ? 10'd0 : p + 10'd1;
   endfunction

   always_comb begin
      wr0_el = arb_io.wr0_level > 10'(WR_THRESH);
      wr1_el = arb_io.wr1_level > 10'(WR_THRESH);
      rd_el  = arb_io.rd_level < 10'(RD_THRESH);
      rd_urg = arb_io.rd_level < 10'(RD_URGENT);
      winner = G_NONE;
      if (rd_urg)                                      winner = G_RD;
      else if (wr1_el && starve_q == 3'(STARVE_MAX))   winner = G_WR1;
      else if (wr0_el)                                 winner = G_WR0;
      else if (rd_el)                                  winner = G_RD;
      else if (wr1_el)                                 winner = G_WR1;
   end

   always_comb begin
      state_d   = state_q;
      p0_d      = p0_q;
      p1_d      = p1_q;
      pr_d      = pr_q;
      starve_d  = starve_q;
      pop_cnt_d = pop_cnt_q;
      ack_cnt_d = ack_cnt_q;
      region_d  = region_q;
      err_d     = err_q;
      rw_d      = rw_q;
      wsel_d    = wsel_q;
      f_addr_d  = f_addr_q;
      frame0_d  = 1'b0;
      pop_ok    = 1'b0;
      // The read region only changes on a frame boundary so the display never tears.
      region_sel = (pr_q == 10'd0) ? arb_io.rd_sel : region_q;

      case (state_q)
         S_IDLE: begin
            if (arb_io.ready && winner != G_NONE) begin
               state_d = S_ISSUE;
               if (winner == G_WR1)
                  starve_d = 3'd0;
               else if (wr1_el && starve_q < 3'(STARVE_MAX))
                  starve_d = starve_q + 3'd1;
               case (winner)
                  G_WR0: begin
                     rw_d     = 1'b0;
                     wsel_d   = 1'b0;
                     f_addr_d = 12'(BASE0) + 12'(p0_q);
                     p0_d     = ptr_inc(p0_q);
                     frame0_d = (p0_q == 10'(PAGES - 1));
                  end
                  G_WR1: begin
                     rw_d     = 1'b0;
                     wsel_d   = 1'b1;
                     f_addr_d = 12'(BASE1) + 12'(p1_q);
                     p1_d     = ptr_inc(p1_q);
                  end
                  G_RD: begin
                     rw_d     = 1'b1;
                     region_d = region_sel;
                     f_addr_d = (region_sel ? 12'(BASE1) : 12'(BASE0)) + 12'(pr_q);
                     pr_d     = ptr_inc(pr_q);
                  end
                  default: ;
               endcase
            end
         end
         S_ISSUE: begin
            pop_cnt_d = 10'd0;
            ack_cnt_d = 4'd0;
            state_d   = S_ACK;
         end
         S_ACK: begin
            if (!arb_io.ready) begin
               state_d = S_BURST;
            end else if (ack_cnt_q == 4'(ACK_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               ack_cnt_d = ack_cnt_q + 4'd1;
            end
         end
         S_BURST: begin
            if (arb_io.ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if ((state_q == S_ACK || state_q == S_BURST) && !rw_q && arb_io.f2s_data_valid) begin
         if (pop_cnt_q < 10'(BURST_LEN)) begin
            pop_ok    = 1'b1;
            pop_cnt_d = pop_cnt_q + 10'd1;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         p0_q      <= 10'd0;
         p1_q      <= 10'd0;
         pr_q      <= 10'd0;
         starve_q  <= 3'd0;
         pop_cnt_q <= 10'd0;
         ack_cnt_q <= 4'd0;
         region_q  <= 1'b0;
         err_q     <= 1'b0;
         rw_q      <= 1'b0;
         wsel_q    <= 1'b0;
         f_addr_q  <= 12'd0;
         frame0_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         p0_q      <= p0_d;
         p1_q      <= p1_d;
         pr_q      <= pr_d;
         starve_q  <= starve_d;
         pop_cnt_q <= pop_cnt_d;
         ack_cnt_q <= ack_cnt_d;
         region_q  <= region_d;
         err_q     <= err_d;
         rw_q      <= rw_d;
         wsel_q    <= wsel_d;
         f_addr_q  <= f_addr_d;
         frame0_q  <= frame0_d;
      end
   end

   assign arb_io.rw_en       = (state_q == S_ISSUE);
   assign arb_io.rw          = rw_q;
   assign arb_io.f_addr      = f_addr_q;
   assign arb_io.wsel        = wsel_q;
   assign arb_io.wr0_pop     = pop_ok & ~wsel_q;
   assign arb_io.wr1_pop     = pop_ok & wsel_q;
   assign arb_io.frame0_done = frame0_q;
   assign arb_io.err         = err_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// tb/tb_sdram_burst_arbiter.sv - directed bench with a grant/pop model and a small controller emulation
module tb_sdram_burst_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sdram_burst_arbiter_if bus();
   sdram_burst_arbiter dut (.clk(clk), .rst_n(rst_n), .arb_io(bus));

   int total = 0;
   int bad   = 0;

   typedef struct {int addr; bit rw; bit wsel;} grant_t;
   grant_t glog[$];

   int mp0, mp1, mpr, mstarve, mcnt, obs_pops, f0_cnt;
   bit mregion, mwsel, cur_wr, cur_src;
   bit err_exp, err_arm, err_pending;
   int ctl_nvalid = 0;
   bit ctl_stall  = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic wait_grants(input int n, input int budget);
      int target = glog.size() + n;
      int cyc = 0;
      while (glog.size() < target && cyc < budget) begin
         @(posedge clk);
         cyc++;
      end
      chk("grant_wait", (glog.size() >= target) ? 1 : 0, 1);
      #1;
   endtask

   task automatic idle_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: decides each grant from the priority rules and tracks pointers/pops.
   initial begin : compare
      int w, ea;
      bit erw, wr0e, wr1e, rdu, rde, ep0, ep1, ef0;
      f0_cnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mp0 = 0; mp1 = 0; mpr = 0; mstarve = 0; mcnt = 0;
            mregion = 0; mwsel = 0; cur_wr = 0; cur_src = 0;
            err_exp = 0; err_arm = 0;
            continue;
         end
         ep0 = 0; ep1 = 0; ef0 = 0;
         err_exp = err_exp | err_arm;
         err_arm = 0;
         if (bus.rw_en) begin
            wr0e = bus.wr0_level > 512;
            wr1e = bus.wr1_level > 512;
            rdu  = bus.rd_level < 64;
            rde  = bus.rd_level < 250;
            w = 0;
            if (rdu)                       w = 3;
            else if (wr1e && mstarve == 4) w = 2;
            else if (wr0e)                 w = 1;
            else if (rde)                  w = 3;
            else if (wr1e)                 w = 2;
            chk("grant_has_winner", (w != 0) ? 1 : 0, 1);
            ea = 0; erw = 0;
            if (w == 1) begin
               ea = mp0; mwsel = 0; ef0 = (mp0 == 599); mp0 = (mp0 + 1) % 600;
            end else if (w == 2) begin
               ea = 600 + mp1; mwsel = 1; mp1 = (mp1 + 1) % 600;
            end else if (w == 3) begin
               if (mpr == 0) mregion = bus.rd_sel;
               ea = (mregion ? 600 : 0) + mpr; erw = 1; mpr = (mpr + 1) % 600;
            end
            if (w == 2) mstarve = 0;
            else if (wr1e && mstarve < 4) mstarve++;
            chk("grant_rw", int'(bus.rw), int'(erw));
            chk("grant_f_addr", int'(bus.f_addr), ea);
            chk("grant_wsel", int'(bus.wsel), int'(mwsel));
            glog.push_back('{int'(bus.f_addr), bus.rw, bus.wsel});
            cur_wr = (w == 1 || w == 2);
            cur_src = (w == 2);
            mcnt = 0;
            obs_pops = 0;
         end else if (bus.f2s_data_valid && cur_wr) begin
            if (mcnt < 512) begin
               mcnt++;
               if (cur_src) ep1 = 1; else ep0 = 1;
            end else begin
               err_arm = 1;
            end
         end
         chk("wr0_pop", int'(bus.wr0_pop), int'(ep0));
         chk("wr1_pop", int'(bus.wr1_pop), int'(ep1));
         chk("frame0_done", int'(bus.frame0_done), int'(ef0));
         if (!err_pending) chk("err", int'(bus.err), int'(err_exp));
         if (bus.wr0_pop || bus.wr1_pop) obs_pops++;
         if (bus.frame0_done) f0_cnt++;
      end
   end

   // Controller emulation: drops ready after each command, streams write words, then returns idle.
   initial begin : ctrl
      int nv;
      bus.ready = 1'b1;
      bus.f2s_data_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.rw_en && !ctl_stall) begin
            nv = bus.rw ? 0 : ctl_nvalid;
            @(posedge clk); #1;
            bus.ready = 1'b0;
            repeat (nv) begin
               bus.f2s_data_valid = 1'b1;
               @(posedge clk); #1;
            end
            bus.f2s_data_valid = 1'b0;
            @(posedge clk); #1;
            bus.ready = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      int base, lat;
      bus.wr0_level = 0; bus.wr1_level = 0; bus.rd_level = 500; bus.rd_sel = 0;
      err_pending = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rw_en", int'(bus.rw_en), 0);
      chk("rst_rw", int'(bus.rw), 0);
      chk("rst_f_addr", int'(bus.f_addr), 0);
      chk("rst_wsel", int'(bus.wsel), 0);
      chk("rst_wr0_pop", int'(bus.wr0_pop), 0);
      chk("rst_wr1_pop", int'(bus.wr1_pop), 0);
      chk("rst_frame0", int'(bus.frame0_done), 0);
      chk("rst_err", int'(bus.err), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // wr0 alone, full bursts
      base = glog.size();
      ctl_nvalid = 512;
      bus.wr0_level = 600;
      wait_grants(3, 3000);
      bus.wr0_level = 0;
      ctl_nvalid = 0;
      idle_wait(600);
      chk("wr0_addr0", glog[base].addr, 0);
      chk("wr0_addr1", glog[base+1].addr, 1);
      chk("wr0_addr2", glog[base+2].addr, 2);
      chk("wr0_pops_per_burst", obs_pops, 512);

      // wr0 pointer wrap
      base = glog.size();
      bus.wr0_level = 600;
      wait_grants(599, 10000);
      bus.wr0_level = 0;
      idle_wait(20);
      chk("wrap_last", glog[base+596].addr, 599);
      chk("wrap_first", glog[base+597].addr, 0);
      chk("frame0_pulses", f0_cnt, 1);

      // wr0 beats a normal read
      base = glog.size();
      bus.wr0_level = 600; bus.rd_level = 100;
      wait_grants(1, 100);
      bus.wr0_level = 0;
      wait_grants(1, 100);
      bus.rd_level = 500;
      idle_wait(20);
      chk("prio_wr0_addr", glog[base].addr, 2);
      chk("prio_wr0_rw", int'(glog[base].rw), 0);
      chk("prio_rd_addr", glog[base+1].addr, 0);
      chk("prio_rd_rw", int'(glog[base+1].rw), 1);

      // urgent read beats wr0
      base = glog.size();
      bus.wr0_level = 600; bus.rd_level = 30;
      wait_grants(1, 100);
      bus.rd_level = 500;
      wait_grants(1, 100);
      bus.wr0_level = 0;
      idle_wait(20);
      chk("urgent_rd_addr", glog[base].addr, 1);
      chk("urgent_rd_rw", int'(glog[base].rw), 1);
      chk("urgent_then_wr0", glog[base+1].addr, 3);

      // read region switch lands on the frame boundary
      base = glog.size();
      bus.rd_level = 100;
      wait_grants(298, 5000);
      bus.rd_sel = 1;
      wait_grants(302, 5000);
      bus.rd_level = 500;
      idle_wait(20);
      chk("region_pr299", glog[base+297].addr, 299);
      chk("region_pr300", glog[base+298].addr, 300);
      chk("region_pr599", glog[base+597].addr, 599);
      chk("region_switch", glog[base+598].addr, 600);
      chk("region_next", glog[base+599].addr, 601);

      // wr1 starvation relief
      base = glog.size();
      ctl_nvalid = 3;
      bus.wr0_level = 600; bus.wr1_level = 600;
      wait_grants(10, 500);
      bus.wr0_level = 0; bus.wr1_level = 0;
      ctl_nvalid = 0;
      idle_wait(40);
      chk("starve_4th_wr0", glog[base+3].addr, 7);
      chk("starve_wr1_addr", glog[base+4].addr, 600);
      chk("starve_wr1_wsel", int'(glog[base+4].wsel), 1);
      chk("starve_back_wsel", int'(glog[base+5].wsel), 0);
      chk("starve_wr1_again", glog[base+9].addr, 601);

      // 513th write word: no pop, sticky err
      base = glog.size();
      ctl_nvalid = 513;
      bus.wr0_level = 600;
      wait_grants(1, 100);
      bus.wr0_level = 0;
      ctl_nvalid = 0;
      idle_wait(530);
      chk("overrun_addr", glog[base].addr, 12);
      chk("overrun_pops", obs_pops, 512);
      chk("overrun_err", int'(bus.err), 1);

      // reset clears sticky err and pointers
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst2_err", int'(bus.err), 0);
      chk("rst2_f_addr", int'(bus.f_addr), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // ACK timeout with ready held high
      ctl_stall = 1;
      err_pending = 1;
      @(posedge clk); #1;
      bus.wr0_level = 600;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!bus.rw_en && lat < 20);
      chk("cmd_latency", lat, 2);
      chk("to_first_addr", int'(bus.f_addr), 0);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!bus.err && lat < 30);
      chk("timeout_cycles", lat, 9);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!bus.rw_en && lat < 20);
      chk("timeout_reissue", lat, 1);
      chk("timeout_ptr_adv", int'(bus.f_addr), 1);
      @(posedge clk); #1;
      bus.wr0_level = 0;
      err_exp = 1;
      err_pending = 0;
      ctl_stall = 0;
      idle_wait(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sdram_burst_arbiter.md
# sdram_burst_arbiter

Schedules full-page (512-word) bursts on the shared SDRAM controller among three clients: two write sources and one read sink. The write sources are the camera pixel FIFO (wr0) and the Sobel output FIFO (wr1). The read sink is the VGA FIFO (rd). The block owns the per-client page pointers and frame regions, drives the controller's `rw`/`rw_en`/`f_addr` command port and gates pops from the granted write source. It sits between the client FIFOs and `sdram_controller`, replacing ad-hoc selection logic in the top-level wrapper.

## Interface
- BURST_LEN, 512, words per burst; pop limit per write grant
- WR_THRESH, 512, write client eligible when level > WR_THRESH
- RD_THRESH, 250, read eligible when rd_level < RD_THRESH
- RD_URGENT, 64, read urgent when rd_level < RD_URGENT
- PAGES, 600, pages per frame region
- BASE0, 0, page base of region 0 (colour)
- BASE1, 600, page base of region 1 (Sobel)
- ACK_TIMEOUT, 8, max cycles for `ready` to fall after a command
- STARVE_MAX, 4, consecutive lost arbitrations before wr1 is forced

Ports:
- clk  in  1  controller clock (143 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- wr0_level  in  10  camera FIFO fill count
- wr1_level  in  10  Sobel FIFO fill count
- rd_level  in  10  VGA FIFO write-side fill count
- rd_sel  in  1  read region request: 0 = colour, 1 = Sobel
- ready  in  1  controller idle
- f2s_data_valid  in  1  controller consuming a write word this cycle
- rw  out  1  1 = read, 0 = write
- rw_en  out  1  command strobe, one cycle
- f_addr  out  12  page address
- wsel  out  1  write-data mux select: 0 = wr0, 1 = wr1
- wr0_pop  out  1  pop camera FIFO
- wr1_pop  out  1  pop Sobel FIFO
- frame0_done  out  1  one-cycle pulse when the wr0 pointer wraps
- err  out  1  sticky: ACK timeout or pop overrun

## Operation
- Pointers are `p0` (wr0), `p1` (wr1) and `pr` (rd), each ranging 0..PAGES-1. Each increments by 1 when its client is granted and wraps from PAGES-1 to 0.
- Address mapping:
  - wr0: `f_addr` = BASE0+p0.
  - wr1: `f_addr` = BASE1+p1.
  - rd: `f_addr` = (region_q ? BASE1 : BASE0)+pr.
- `region_q` is loaded from `rd_sel` only when a read is granted with pr==0. This means a region switch takes effect at a frame boundary only, with no tearing.
- Arbitration is evaluated in IDLE when `ready`=1. Priority order:
  1. Urgent read.
  2. wr1 if `starve`==STARVE_MAX.
  3. wr0.
  4. Normal read.
  5. wr1.
- `starve` counts grants to other clients while wr1 was eligible. It is cleared on a wr1 grant and saturates at STARVE_MAX.
- FSM states:
  - IDLE: on a winner → ISSUE.
  - ISSUE: 1 cycle, `rw_en`=1 → ACK.
  - ACK: on `ready`=0 → BURST. If the ACK cycle count reaches ACK_TIMEOUT, set `err` → IDLE; the pointer is still advanced.
  - BURST: on `ready`=1 → IDLE.
- `wsel` is registered. It loads on a write grant and holds until the next write grant; read grants do not change it.
- Pop gating:
  - `wrN_pop` = `f2s_data_valid` & (state ACK or BURST) & write grant & `wsel`==N & `pop_cnt`<BURST_LEN. The pop is combinational so the FIFO data is valid before the next edge.
  - `pop_cnt` clears in ISSUE.
  - `f2s_data_valid` arriving with `pop_cnt`==BURST_LEN sets `err` and produces no pop.
- `frame0_done` pulses in the cycle a wr0 grant wraps `p0` from PAGES-1 to 0.

## Timing
- Reset values:
  - All outputs 0. The FSM state is IDLE.
  - `p0`, `p1`, `pr`, `starve` and `pop_cnt` are 0.
  - `region_q` is 0 and `err` is 0.
- Reset mid-burst aborts immediately. The controller shares `rst_n`, so no recovery sequence is needed.
- Command latency: eligibility with `ready`=1 sampled at edge k gives `rw_en`, `rw` and `f_addr` registered high during cycle k+1 only.
- `f_addr`, `rw` and `wsel` stay stable from ISSUE until the next ISSUE.
- Levels are sampled in IDLE only. A level change during a burst does not preempt the burst.
- Gap: the earliest next `rw_en` is 2 cycles after `ready` returns high (BURST→IDLE, then IDLE→ISSUE).
- Simultaneous eligibility resolves strictly by the priority list in the same cycle; there are no ties.

## Test plan
- Reset, then wr0_level=600 with others idle:
  - `rw_en` pulses with `rw`=0 and `f_addr`=0, then 1, 2, ...
  - Exactly 512 `wr0_pop` per burst; `wsel`=0.
- 600 wr0 bursts:
  - `f_addr` wraps from 599 to 0.
  - `frame0_done` pulses once, on the wrap.
- wr0_level=600 and rd_level=100 together:
  - wr0 is granted first, then the read (`rw`=1, `f_addr`=0).
- Same case with rd_level=30:
  - The read is granted first.
- Set rd_sel=1 at pr=300:
  - Reads continue at 300..599.
  - After the wrap, reads go to `f_addr`=600.
- wr0 and wr1 permanently eligible, reads idle:
  - wr1 is granted once after 4 wr0 grants; `wsel` toggles accordingly.
- Hold `ready`=1 after `rw_en`:
  - After 8 cycles `err`=1 and the FSM returns to IDLE.
- Inject a 513th `f2s_data_valid` in one write burst:
  - No pop occurs and `err`=1.
